// File: rtl/sar_bias_pkg.sv
// Shared types and constants for the SAR bias controller.
// Optional feature macro: SAR_BIAS_AVG_EN (3-sample majority decision per bit).
package sar_bias_pkg;

   localparam int unsigned CODE_W = 8;
   localparam int unsigned IDAC_W = 4;
   localparam int unsigned BIT_W  = 3;

`ifdef SAR_BIAS_AVG_EN
   localparam int unsigned SAMPLE_CYCLES = 3;
`else
   localparam int unsigned SAMPLE_CYCLES = 1;
`endif

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      SETTLE,
      SAMPLE,
      DONE
   } sar_state_e;

   localparam logic [CODE_W-1:0] IB_RST    = 8'h7F;
   localparam logic [CODE_W-1:0] IBF_RST   = 8'h00;
   localparam logic [CODE_W-1:0] DIODE_RST = 8'hFF;
   localparam logic [IDAC_W-1:0] IDAC_RST  = 4'h6;

   // Larger of two unsigned values, for elaboration-time sizing.
   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sar_bias_ctrl_if.sv
// Test-wrapper side of the SAR bias controller: start/abort, static trims, status.
interface sar_bias_ctrl_if;
   import sar_bias_pkg::*;

   logic              start_i;
   logic              abort_i;
   logic [CODE_W-1:0] cfg_ibf_i;
   logic [CODE_W-1:0] cfg_diode_i;
   logic [IDAC_W-1:0] cfg_idac_i;
   logic              busy_o;
   logic              done_o;
   logic [CODE_W-1:0] result_o;

   modport master (
      output start_i, abort_i, cfg_ibf_i, cfg_diode_i, cfg_idac_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, abort_i, cfg_ibf_i, cfg_diode_i, cfg_idac_i,
      output busy_o, done_o, result_o
   );

endinterface

// File: rtl/sar_bias_timer.sv
// Loadable down-counter shared by the RESET, SETTLE and SAMPLE phases.
module sar_bias_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             count,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load has priority; counting saturates at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (count && (cnt != '0))
         cnt <= cnt - CNT_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sar_bias_ctrl.sv
// Successive-approximation search of the ib bias code with per-trial analog reset.
// Optional feature macro: SAR_BIAS_AVG_EN (3-sample majority decision per bit).
module sar_bias_ctrl
   import sar_bias_pkg::*;
#(
   parameter int unsigned RES_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   sar_bias_ctrl_if.slave    bus,
   input  logic              cmp_i,
   output logic [CODE_W-1:0] ib,
   output logic [CODE_W-1:0] ibf,
   output logic              res_n,
   output logic [CODE_W-1:0] diode,
   output logic [IDAC_W-1:0] idac_o
);

   localparam int unsigned CNT_MAX = max2(max2(RES_CYCLES, SETTLE_CYCLES), SAMPLE_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RES_LOAD    = CNT_W'(RES_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

   sar_state_e        state, state_nxt;
   logic [CODE_W-1:0] code_q, code_nxt;
   logic [BIT_W-1:0]  bit_q, bit_nxt;
   logic [CODE_W-1:0] ib_nxt, ibf_nxt, diode_nxt, result_nxt;
   logic [IDAC_W-1:0] idac_nxt;
   logic              res_n_nxt, busy_nxt, done_nxt;
   logic              t_load, t_count, t_zero;
   logic [CNT_W-1:0]  t_val;
   logic              dec_c;
   logic [CODE_W-1:0] trial_mask_c, next_mask_c, code_dec_c;

   sar_bias_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (t_load),
      .load_val (t_val),
      .count    (t_count),
      .zero     (t_zero)
   );

`ifdef SAR_BIAS_AVG_EN
   logic [1:0] smp_q, smp_nxt;

   // Majority of the two earlier samples and the final one.
   assign dec_c = (smp_q[1] & smp_q[0]) | (smp_q[1] & cmp_i) | (smp_q[0] & cmp_i);

   // Sample history for the majority vote.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) smp_q <= '0;
      else          smp_q <= smp_nxt;
   end
`else
   assign dec_c = cmp_i;
`endif

   assign trial_mask_c = CODE_W'(1) << bit_q;
   assign next_mask_c  = CODE_W'(1) << (bit_q - BIT_W'(1));
   assign code_dec_c   = code_q | (dec_c ? trial_mask_c : '0);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; abort wins over everything outside IDLE.
   always_comb begin
      state_nxt = state;
      if ((state != IDLE) && bus.abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start_i && !bus.abort_i) state_nxt = RESET;
            RESET:   if (t_zero) state_nxt = SETTLE;
            SETTLE:  if (t_zero) state_nxt = SAMPLE;
            SAMPLE:  if (t_zero) state_nxt = (bit_q == '0) ? DONE : RESET;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs, working code and timer controls.
   always_comb begin
      ib_nxt     = ib;
      ibf_nxt    = ibf;
      diode_nxt  = diode;
      idac_nxt   = idac_o;
      res_n_nxt  = res_n;
      busy_nxt   = bus.busy_o;
      done_nxt   = 1'b0;
      result_nxt = bus.result_o;
      code_nxt   = code_q;
      bit_nxt    = bit_q;
      t_load     = 1'b0;
      t_val      = '0;
      t_count    = 1'b0;
`ifdef SAR_BIAS_AVG_EN
      smp_nxt    = smp_q;
`endif
      if ((state != IDLE) && bus.abort_i) begin
         ib_nxt    = IB_RST;
         res_n_nxt = 1'b1;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i && !bus.abort_i) begin
                  ibf_nxt   = bus.cfg_ibf_i;
                  diode_nxt = bus.cfg_diode_i;
                  idac_nxt  = bus.cfg_idac_i;
                  code_nxt  = '0;
                  bit_nxt   = BIT_W'(CODE_W - 1);
                  ib_nxt    = CODE_W'(1) << (CODE_W - 1);
                  res_n_nxt = 1'b0;
                  busy_nxt  = 1'b1;
                  t_load    = 1'b1;
                  t_val     = RES_LOAD;
               end
            end
            RESET: begin
               if (t_zero) begin
                  res_n_nxt = 1'b1;
                  t_load    = 1'b1;
                  t_val     = SETTLE_LOAD;
               end else begin
                  t_count = 1'b1;
               end
            end
            SETTLE: begin
               if (t_zero) begin
                  t_load = 1'b1;
                  t_val  = SAMPLE_LOAD;
               end else begin
                  t_count = 1'b1;
               end
            end
            SAMPLE: begin
               if (t_zero) begin
                  code_nxt = code_dec_c;
                  if (bit_q == '0) begin
                     ib_nxt     = code_dec_c;
                     result_nxt = code_dec_c;
                     done_nxt   = 1'b1;
                  end else begin
                     bit_nxt   = bit_q - BIT_W'(1);
                     ib_nxt    = code_dec_c | next_mask_c;
                     res_n_nxt = 1'b0;
                     t_load    = 1'b1;
                     t_val     = RES_LOAD;
                  end
               end else begin
                  t_count = 1'b1;
`ifdef SAR_BIAS_AVG_EN
                  smp_nxt = {smp_q[0], cmp_i};
`endif
               end
            end
            DONE:    busy_nxt = 1'b0;
            default: ;
         endcase
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ib           <= IB_RST;
         ibf          <= IBF_RST;
         diode        <= DIODE_RST;
         idac_o       <= IDAC_RST;
         res_n        <= 1'b1;
         bus.busy_o   <= 1'b0;
         bus.done_o   <= 1'b0;
         bus.result_o <= '0;
         code_q       <= '0;
         bit_q        <= '0;
      end else begin
         ib           <= ib_nxt;
         ibf          <= ibf_nxt;
         diode        <= diode_nxt;
         idac_o       <= idac_nxt;
         res_n        <= res_n_nxt;
         bus.busy_o   <= busy_nxt;
         bus.done_o   <= done_nxt;
         bus.result_o <= result_nxt;
         code_q       <= code_nxt;
         bit_q        <= bit_nxt;
      end
   end

endmodule

// File: tb/tb_sar_bias_ctrl.sv
// Scoreboard bench for sar_bias_ctrl with a behavioural SAR reference model.
module tb_sar_bias_ctrl;

   localparam int unsigned R = 4;
   localparam int unsigned S = 16;
`ifdef SAR_BIAS_AVG_EN
   localparam int unsigned NS = 3;
`else
   localparam int unsigned NS = 1;
`endif
   localparam int PBI = int'(R + S + NS);

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmp_i = 1'b0;
   logic [7:0] ib, ibf, diode;
   logic       res_n;
   logic [3:0] idac_o;

   sar_bias_ctrl_if bus();

   sar_bias_ctrl #(.RES_CYCLES(R), .SETTLE_CYCLES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .cmp_i   (cmp_i),
      .ib      (ib),
      .ibf     (ibf),
      .res_n   (res_n),
      .diode   (diode),
      .idac_o  (idac_o)
   );

   always #50 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] res;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: comparator behaviour and the binary search over it.
   int         cmp_mode = 0;
   logic [7:0] cmp_thr = 8'h00;
   int         c0 = 0;
   int         off;
   logic [7:0] m_trials[8];
   logic [7:0] m_result;

   function automatic bit cmp_ref(input int mode, input logic [7:0] thr, input logic [7:0] code);
      case (mode)
         0:       return code <= thr;
         1:       return 1'b1;
         2:       return 1'b0;
         default: return 1'b1;   // pattern 1,0,1 -> majority keeps the bit
      endcase
   endfunction

   function automatic void sar_model(input int mode, input logic [7:0] thr);
      logic [7:0] acc;
      logic [7:0] t;
      acc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         t = acc | (8'h80 >> k);
         m_trials[k] = t;
         if (cmp_ref(mode, thr, t)) acc = t;
      end
      m_result = acc;
   endfunction

   // Analog comparator stand-in, updated mid-cycle from the current ib.
   always @(negedge clk) begin
      off = cyc - (c0 + 1);
      case (cmp_mode)
         0:       cmp_i = (ib <= cmp_thr);
         1:       cmp_i = 1'b1;
         2:       cmp_i = 1'b0;
         default: cmp_i = (off >= 0) ? ((off % PBI) != int'(R + S + 1)) : 1'b0;
      endcase
   end

   // Monitor: every done_o must match the oldest expected result and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && bus.done_o) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: done_o=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("result_o", 32'(bus.result_o), 32'(e.res));
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("ib_at_done", 32'(ib), 32'(e.res));
         end
      end
   end

   task automatic check_rst(input string tag);
      check({tag, "_ib"},     32'(ib),           32'h7F);
      check({tag, "_ibf"},    32'(ibf),          32'h00);
      check({tag, "_res_n"},  32'(res_n),        32'h1);
      check({tag, "_diode"},  32'(diode),        32'hFF);
      check({tag, "_idac"},   32'(idac_o),       32'h6);
      check({tag, "_result"}, 32'(bus.result_o), 32'h00);
      check({tag, "_busy"},   32'(bus.busy_o),   32'h0);
      check({tag, "_done"},   32'(bus.done_o),   32'h0);
   endtask

   task automatic run_search(input int mode, input logic [7:0] thr, input bit extra,
                             input logic [7:0] ci, input logic [7:0] cd, input logic [3:0] cq);
      int         lows, falls, k;
      logic       prev;
      logic [7:0] seen[8];
      cmp_mode = mode;
      cmp_thr  = thr;
      sar_model(mode, thr);
      @(negedge clk);
      bus.cfg_ibf_i   = ci;
      bus.cfg_diode_i = cd;
      bus.cfg_idac_i  = cq;
      bus.start_i     = 1'b1;
      c0 = cyc;
      sb.push_back('{m_result, c0 + 1 + 8 * PBI});
      @(negedge clk);
      bus.start_i     = 1'b0;
      bus.cfg_ibf_i   = 8'($urandom);
      bus.cfg_diode_i = 8'($urandom);
      bus.cfg_idac_i  = 4'($urandom);
      check("edge1_ibf",   32'(ibf),        32'(ci));
      check("edge1_diode", 32'(diode),      32'(cd));
      check("edge1_idac",  32'(idac_o),     32'(cq));
      check("edge1_ib",    32'(ib),         32'h80);
      check("edge1_res_n", 32'(res_n),      32'h0);
      check("edge1_busy",  32'(bus.busy_o), 32'h1);
      for (int i = 0; i < 8; i++) seen[i] = 8'h00;
      seen[0] = ib;
      lows = 1; falls = 1; prev = 1'b0; k = 0;
      while (bus.busy_o && k < 8 * PBI + 40) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (extra && bus.busy_o && ($urandom_range(0, 7) == 0)) bus.start_i = 1'b1;
         if (!res_n) begin
            lows++;
            if (prev) begin
               if (falls < 8) seen[falls] = ib;
               falls++;
            end
         end
         prev = res_n;
         k++;
      end
      bus.start_i = 1'b0;
      check("search_ends", 32'(bus.busy_o), 32'h0);
      check("res_n_pulses", 32'(falls), 32'd8);
      check("res_n_low_cycles", 32'(lows), 32'(8 * R));
      for (int i = 0; i < 8; i++) check("trial_ib", 32'(seen[i]), 32'(m_trials[i]));
      check("hold_ibf",   32'(ibf),          32'(ci));
      check("hold_diode", 32'(diode),        32'(cd));
      check("hold_idac",  32'(idac_o),       32'(cq));
      check("idle_ib",    32'(ib),           32'(m_result));
      check("idle_result",32'(bus.result_o), 32'(m_result));
   endtask

   task automatic abort_test();
      logic [7:0] prior;
      int         tgt, g;
      prior = bus.result_o;
      cmp_mode = 0;
      cmp_thr  = 8'($urandom);
      sar_model(0, cmp_thr);
      @(negedge clk);
      bus.start_i = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.start_i = 1'b0;
      tgt = c0 + 1 + 3 * PBI + int'(R) + 5;
      g = 0;
      while (cyc != tgt && g < 1000) begin
         @(negedge clk);
         g++;
      end
      check("abort_reached", 32'(cyc), 32'(tgt));
      check("bit4_settle_ib", 32'(ib), 32'(m_trials[3]));
      check("bit4_settle_res_n", 32'(res_n), 32'h1);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      check("abort_ib",     32'(ib),           32'h7F);
      check("abort_res_n",  32'(res_n),        32'h1);
      check("abort_busy",   32'(bus.busy_o),   32'h0);
      check("abort_result", 32'(bus.result_o), 32'(prior));
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 32'(bus.busy_o), 32'h0);
   endtask

   initial begin
      #(100 * 30000);
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      bus.start_i     = 1'b0;
      bus.abort_i     = 1'b0;
      bus.cfg_ibf_i   = 8'h00;
      bus.cfg_diode_i = 8'h00;
      bus.cfg_idac_i  = 4'h0;
      repeat (3) @(negedge clk);
      check_rst("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_rst("after_reset");

      run_search(0, 8'hA5, 1'b0, 8'h3C, 8'h0F, 4'h9);
      run_search(1, 8'h00, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
      run_search(2, 8'h00, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
`ifdef SAR_BIAS_AVG_EN
      run_search(3, 8'h00, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
`endif

      // start together with abort in IDLE is ignored
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      check("start_abort_busy", 32'(bus.busy_o), 32'h0);
      check("start_abort_res_n", 32'(res_n), 32'h1);

      abort_test();
      run_search(0, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));

      for (int r = 0; r < 8; r++)
         run_search(int'($urandom_range(0, 2)), 8'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 4'($urandom));

      run_search(0, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 4'($urandom));

      // asynchronous reset in the middle of a search
      cmp_mode = 0;
      cmp_thr  = 8'($urandom);
      @(negedge clk);
      bus.start_i = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (60) @(negedge clk);
      #10;
      reset_n = 1'b0;
      #1;
      check_rst("async_reset");
      g = 0;
      @(negedge clk);
      reset_n = 1'b1;
      run_search(0, 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
